timer_bank: RTL

Multi-channel programmable timer for the Forth CPU peripheral bus; the successor to the single one-shot counter. NCHAN independent channels share one prescaler. Each channel has a writable reload value and a one-shot or periodic mode. Each channel reports completion with a one-clock pulse and a sticky expired flag that software acknowledges, so the block can drive interrupts as well as simple delay lines.

---
 rtl/timer_bank.sv | 117 +++++++++++
 1 files changed

// File: rtl/timer_bank.sv
// NCHAN-channel one-shot/periodic timer sharing one free-running prescaler.
// Outputs registered except the o_rd_count mux; there is no backpressure, and control strobes are accepted every clock.
module timer_bank #(
  parameter int NCHAN = 4,
  parameter int WIDTH = 16,
  parameter int PBITS = 8,
  localparam int CBITS = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [PBITS-1:0] i_prescale,
  input  logic             i_wr,
  input  logic [CBITS-1:0] i_wr_chan,
  input  logic [WIDTH-1:0] i_wr_load,
  input  logic             i_wr_mode,
  input  logic [NCHAN-1:0] i_start,
  input  logic [NCHAN-1:0] i_stop,
  input  logic [NCHAN-1:0] i_ack,
  input  logic [CBITS-1:0] i_rd_chan,
  output logic [WIDTH-1:0] o_rd_count,
  output logic [NCHAN-1:0] o_busy,
  output logic [NCHAN-1:0] o_pulse,
  output logic [NCHAN-1:0] o_expired
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] load;
    logic [WIDTH-1:0] cmp;
    logic [WIDTH-1:0] count;
    logic             mode;
    logic             run_mode;
    logic [1:0]       state;
  } chan_t;

  logic [PBITS-1:0]            p_cnt;
  logic                        tick;
  logic [NCHAN-1:0][WIDTH-1:0] count_all;

  // Wraps at p_cnt == i_prescale, or at 2^PBITS if the divider was lowered underneath it.
  assign tick = i_en && (p_cnt == i_prescale);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      p_cnt <= '0;
    end else if (i_en) begin
      p_cnt <= tick ? '0 : p_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    chan_t ch_q;
    logic  pulse_q;
    logic  exp_q;
    logic  wr_hit;
    logic  expire;

    assign wr_hit = i_wr && (i_wr_chan == CBITS'(c));
    // Stop and start both pre-empt an expiring tick.
    assign expire = !i_stop[c] && !i_start[c] && (ch_q.state == ST_RUN) && tick &&
                    (ch_q.count == ch_q.cmp);

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        ch_q    <= '0;
        pulse_q <= 1'b0;
        exp_q   <= 1'b0;
      end else begin
        pulse_q <= expire;
        if (wr_hit) begin
          ch_q.load <= i_wr_load;
          ch_q.mode <= i_wr_mode;
        end
        if (i_stop[c]) begin
          ch_q.state <= ST_IDLE;
        end else if (i_start[c]) begin
          ch_q.cmp      <= ch_q.load;
          ch_q.run_mode <= ch_q.mode;
          ch_q.count    <= '0;
          ch_q.state    <= ST_RUN;
        end else if (expire) begin
          if (ch_q.run_mode) begin
            ch_q.count    <= '0;
            ch_q.cmp      <= ch_q.load;
            ch_q.run_mode <= ch_q.mode;
          end else begin
            ch_q.state <= ST_DONE;
          end
        end else if ((ch_q.state == ST_RUN) && tick) begin
          ch_q.count <= ch_q.count + 1'b1;
        end
        if (expire) begin
          exp_q <= 1'b1;
        end else if (i_ack[c]) begin
          exp_q <= 1'b0;
        end
      end
    end

    assign count_all[c]  = ch_q.count;
    assign o_busy[c]     = (ch_q.state == ST_RUN);
    assign o_pulse[c]    = pulse_q;
    assign o_expired[c]  = exp_q;
  end

  always_comb begin
    o_rd_count = '0;
    if (32'(i_rd_chan) < NCHAN) begin
      o_rd_count = count_all[i_rd_chan];
    end
  end

endmodule
